mb2ip_bus_arbiter: RTL and testbench
====================================

Name: mb2ip_bus_arbiter

Overview:
- Shares the single MB2IP register-access bus to sata_test_logic between two requesters:
  - port M0: MicroBlaze-side bridge;
  - port M1: the on-chip SATA test sequencer.
- Round-robin arbitration, one outstanding transfer at a time.
- Drives CS/RNW/Addr/Data/BE, waits for IP2MB_RdAck/WrAck, and returns data, ack and error to the granted requester.
- A watchdog terminates transfers the slave never acknowledges.

Parameters:
- ADDR_W, 32, address width, bit order [0:ADDR_W-1].
- DATA_W, 32, data width, bit order [0:DATA_W-1]; BE width is DATA_W/8.
- TIMEOUT, 255, cycles to wait for slave ack before forced termination; legal range 2..65535.

Ports:
- MB2IP_Clk  in  1  single clock.
- MB2IP_Reset_n  in  1  asynchronous, active-low reset.
- mN_req (N=0,1)  in  1  request, level; held until mN_ack.
- mN_rnw  in  1  1 = read, 0 = write.
- mN_addr  in  ADDR_W  address.
- mN_wdata  in  DATA_W  write data.
- mN_be  in  DATA_W/8  byte enables.
- mN_ack  out  1  one-cycle completion pulse.
- mN_rdata  out  DATA_W  read data, valid with mN_ack, held until the next completion to that port.
- mN_err  out  1  qualifies mN_ack: slave error or timeout.
- MB2IP_CS  out  1  slave select.
- MB2IP_RNW  out  1  slave read/write select.
- MB2IP_Addr  out  ADDR_W  slave address.
- MB2IP_Data  out  DATA_W  slave write data.
- MB2IP_BE  out  DATA_W/8  slave byte enables.
- IP2MB_Data  in  DATA_W  slave read data.
- IP2MB_RdAck  in  1  slave read acknowledge.
- IP2MB_WrAck  in  1  slave write acknowledge.
- IP2MB_Error  in  1  slave error, qualifies either ack.
- busy  out  1  transfer in progress (state != IDLE).
- timeout_cnt  out  8  saturating count of timeouts; saturates at 255.

Behaviour:
- Reset (async assert, sync release) values:
  - MB2IP_CS=0, MB2IP_RNW=1, MB2IP_Addr/Data/BE=0;
  - all mN_ack/mN_err=0, mN_rdata=0;
  - busy=0, timeout_cnt=0;
  - last_grant=1, so M0 wins the first contention.
- All outputs are registered.
- FSM states IDLE, XFER, DONE.
- IDLE:
  - If any req is sampled high, select the winner:
    - only one req high → that requester;
    - both high → the requester != last_grant.
  - Latch the winner's rnw/addr/wdata/be onto the MB2IP outputs, set CS=1, update last_grant, clear the watchdog, go to XFER.
  - CS rises the cycle after req is first sampled.
- XFER:
  - CS and all bus fields hold stable.
  - The watchdog increments each cycle.
  - RdAck|WrAck sampled high:
    - CS→0;
    - capture IP2MB_Data into the winner's rdata if rnw=1; write-port rdata is unchanged;
    - err=IP2MB_Error;
    - go to DONE.
  - Otherwise, when the watchdog reaches TIMEOUT-1:
    - CS→0, err=1, rdata unchanged;
    - timeout_cnt+1 (saturating);
    - go to DONE.
  - Ack in the same cycle as watchdog expiry: ack wins, no timeout counted.
  - RdAck and WrAck both high: treated as a single ack.
- DONE: winner's mN_ack=1 for exactly one cycle with mN_err valid, then IDLE. The loser's ack/err stay 0.
- Latency:
  - req sampled → CS high: 1 cycle.
  - slave ack sampled → CS low: 1 cycle.
  - slave ack sampled → mN_ack: 2 cycles.
  - Minimum req-to-ack for a 1-cycle slave: 4 cycles.
- Requester rules:
  - Hold req and all fields stable until ack.
  - Drop req in the cycle after ack.
  - IDLE re-samples one cycle after DONE, so a dropped req never reissues.
  - req held continuously issues back-to-back transfers, alternating with the other port under contention.
- Spurious RdAck/WrAck/Error in IDLE or DONE: ignored, no state change.
- Reset mid-transfer: immediate return to reset values, no ack issued; in-flight transfer is abandoned.
- Watchdog width: clog2(TIMEOUT+1).

Decomposition:
- Shared package mb2ip_pkg:
  - FSM state enum (IDLE/XFER/DONE);
  - default ADDR_W/DATA_W constants;
  - requester index constants M0=0, M1=1.
- One natural sub-module: mb2ip_rr_arb2, a 2-way round-robin grant with last_grant register and update-on-accept input.
- Watchdog and datapath mux stay in the top.

Test Plan:
- Single read: m0 req, rnw=1, addr=0x0000_0010; slave returns RdAck with Data=0xDEAD_BEEF 2 cycles after CS → CS high for 3 cycles, m0_ack one cycle with m0_rdata=0xDEAD_BEEF, m0_err=0.
- Contention: m0 and m1 req in the same cycle after reset → M0 granted first, M1 second; hold both for 4 transfers → grant order M0, M1, M0, M1 with no idle CS cycles beyond the DONE/IDLE gap.
- Write with error: m1 write addr=0x24, data=0x1234_5678, be=4'b0011; slave WrAck+Error → MB2IP_Data/BE match during CS, m1_ack with m1_err=1, m1_rdata unchanged.
- Timeout: TIMEOUT=8, slave silent → CS deasserts after 8 XFER cycles, m0_ack+m0_err=1, timeout_cnt 0→1. Ack on the expiry cycle → err=0, timeout_cnt unchanged. 260 timeouts → timeout_cnt=255.
- Reset mid-transfer: assert MB2IP_Reset_n low during XFER → CS=0 asynchronously, no ack; after release m1 requests alone → granted; m0 then wins the next contention.
- Spurious ack: pulse RdAck with Error while IDLE → no outputs change, busy stays 0.

Source files
------------

// File: rtl/mb2ip_pkg.sv
// Shared types and constants for the MB2IP bus arbiter: FSM state encoding,
// default bus widths and requester indices.
package mb2ip_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam int M0 = 0;
  localparam int M1 = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mb2ip_rr_arb2.sv
// Two-way round-robin grant. The last-grant register only moves when the
// caller accepts the grant, so a stalled arbiter keeps its fairness order.
module mb2ip_rr_arb2
  import mb2ip_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic       o_grant,
  output logic       o_valid
);

  logic r_last_grant;

  assign o_valid = |i_req;
  // Under contention the port that did not win last time goes next.
  assign o_grant = (&i_req) ? ~r_last_grant : i_req[M1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= 1'b1;
    end else if (i_accept) begin
      r_last_grant <= o_grant;
    end
  end

endmodule

// File: rtl/mb2ip_bus_arbiter.sv
// Shares the MB2IP register bus between the MicroBlaze bridge (M0) and the
// SATA test sequencer (M1), one transfer at a time, with an ack watchdog.
module mb2ip_bus_arbiter
  import mb2ip_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                  MB2IP_Clk,
  input  logic                  MB2IP_Reset_n,
  input  logic                  m0_req,
  input  logic                  m0_rnw,
  input  logic [0:ADDR_W-1]     m0_addr,
  input  logic [0:DATA_W-1]     m0_wdata,
  input  logic [0:DATA_W/8-1]   m0_be,
  output logic                  m0_ack,
  output logic [0:DATA_W-1]     m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_rnw,
  input  logic [0:ADDR_W-1]     m1_addr,
  input  logic [0:DATA_W-1]     m1_wdata,
  input  logic [0:DATA_W/8-1]   m1_be,
  output logic                  m1_ack,
  output logic [0:DATA_W-1]     m1_rdata,
  output logic                  m1_err,
  output logic                  MB2IP_CS,
  output logic                  MB2IP_RNW,
  output logic [0:ADDR_W-1]     MB2IP_Addr,
  output logic [0:DATA_W-1]     MB2IP_Data,
  output logic [0:DATA_W/8-1]   MB2IP_BE,
  input  logic [0:DATA_W-1]     IP2MB_Data,
  input  logic                  IP2MB_RdAck,
  input  logic                  IP2MB_WrAck,
  input  logic                  IP2MB_Error,
  output logic                  busy,
  output logic [7:0]            timeout_cnt
);

  localparam int BE_W = DATA_W / 8;
  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic              r_win;
  logic              r_err;
  logic [WD_W-1:0]   r_wd;

  logic [1:0]        w_req;
  logic              w_grant;
  logic              w_valid;
  logic              w_accept;
  logic              w_slv_ack;
  logic              w_wd_exp;
  logic              w_sel_rnw;
  logic [0:ADDR_W-1] w_sel_addr;
  logic [0:DATA_W-1] w_sel_wdata;
  logic [0:BE_W-1]   w_sel_be;

  assign w_req[M0] = m0_req;
  assign w_req[M1] = m1_req;

  // The cycle that presents an ack is skipped so a requester dropping req
  // in response to that ack is never re-granted.
  assign w_accept  = (r_state == ST_IDLE) && w_valid && !m0_ack && !m1_ack;
  assign w_slv_ack = IP2MB_RdAck | IP2MB_WrAck;
  assign w_wd_exp  = (r_wd == WD_W'(TIMEOUT - 1));

  assign w_sel_rnw   = w_grant ? m1_rnw   : m0_rnw;
  assign w_sel_addr  = w_grant ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_grant ? m1_wdata : m0_wdata;
  assign w_sel_be    = w_grant ? m1_be    : m0_be;

  mb2ip_rr_arb2 u_arb (
    .i_clk    (MB2IP_Clk),
    .i_rst_n  (MB2IP_Reset_n),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_grant  (w_grant),
    .o_valid  (w_valid)
  );

  always_ff @(posedge MB2IP_Clk or negedge MB2IP_Reset_n) begin
    if (!MB2IP_Reset_n) begin
      r_state     <= ST_IDLE;
      r_win       <= 1'b0;
      r_err       <= 1'b0;
      r_wd        <= '0;
      MB2IP_CS    <= 1'b0;
      MB2IP_RNW   <= 1'b1;
      MB2IP_Addr  <= '0;
      MB2IP_Data  <= '0;
      MB2IP_BE    <= '0;
      m0_ack      <= 1'b0;
      m0_err      <= 1'b0;
      m0_rdata    <= '0;
      m1_ack      <= 1'b0;
      m1_err      <= 1'b0;
      m1_rdata    <= '0;
      busy        <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            MB2IP_CS   <= 1'b1;
            MB2IP_RNW  <= w_sel_rnw;
            MB2IP_Addr <= w_sel_addr;
            MB2IP_Data <= w_sel_wdata;
            MB2IP_BE   <= w_sel_be;
            r_win      <= w_grant;
            r_wd       <= '0;
            busy       <= 1'b1;
            r_state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          // A slave ack on the expiry cycle takes priority over the timeout.
          if (w_slv_ack) begin
            MB2IP_CS <= 1'b0;
            r_err    <= IP2MB_Error;
            if (MB2IP_RNW) begin
              if (r_win) m1_rdata <= IP2MB_Data;
              else       m0_rdata <= IP2MB_Data;
            end
            r_state <= ST_DONE;
          end else if (w_wd_exp) begin
            MB2IP_CS <= 1'b0;
            r_err    <= 1'b1;
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            r_state  <= ST_DONE;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        ST_DONE: begin
          if (r_win) begin
            m1_ack <= 1'b1;
            m1_err <= r_err;
          end else begin
            m0_ack <= 1'b1;
            m0_err <= r_err;
          end
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          MB2IP_CS <= 1'b0;
          busy     <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mb2ip_bus_arbiter.sv
// Directed bench for mb2ip_bus_arbiter: a behavioural slave, a completion
// scoreboard, and a linear sequence of arbitration, error and timeout cases.
module tb_mb2ip_bus_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_rnw, m1_req, m1_rnw;
  logic [0:31] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [0:3]  m0_be, m1_be;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [0:31] m0_rdata, m1_rdata;
  logic        MB2IP_CS, MB2IP_RNW;
  logic [0:31] MB2IP_Addr, MB2IP_Data;
  logic [0:3]  MB2IP_BE;
  logic [0:31] IP2MB_Data;
  logic        IP2MB_RdAck, IP2MB_WrAck, IP2MB_Error;
  logic        busy;
  logic [7:0]  timeout_cnt;

  always #5 clk = ~clk;

  mb2ip_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .MB2IP_Clk(clk), .MB2IP_Reset_n(rst_n),
    .m0_req(m0_req), .m0_rnw(m0_rnw), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_rnw(m1_rnw), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .MB2IP_CS(MB2IP_CS), .MB2IP_RNW(MB2IP_RNW), .MB2IP_Addr(MB2IP_Addr),
    .MB2IP_Data(MB2IP_Data), .MB2IP_BE(MB2IP_BE),
    .IP2MB_Data(IP2MB_Data), .IP2MB_RdAck(IP2MB_RdAck), .IP2MB_WrAck(IP2MB_WrAck),
    .IP2MB_Error(IP2MB_Error), .busy(busy), .timeout_cnt(timeout_cnt)
  );

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rdata [2];
  int          n_chk = 0;
  int          n_fail = 0;

  // slave behaviour: slv_lat = CS cycles until ack (0 = never answers)
  int          slv_lat = 1;
  int          slv_cnt = 0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  logic        spur = 1'b0;

  int cs_run = 0, cs_len = 0, gap_run = 0, gap_len = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    IP2MB_RdAck = 1'b0;
    IP2MB_WrAck = 1'b0;
    IP2MB_Error = 1'b0;
    if (MB2IP_CS) begin
      slv_cnt++;
      if (slv_lat != 0 && slv_cnt == slv_lat) begin
        if (MB2IP_RNW) IP2MB_RdAck = 1'b1;
        else           IP2MB_WrAck = 1'b1;
        IP2MB_Error = slv_err;
        IP2MB_Data  = slv_rdata ^ MB2IP_Addr;
      end
    end else begin
      slv_cnt = 0;
      if (spur) begin
        IP2MB_RdAck = 1'b1;
        IP2MB_Error = 1'b1;
        IP2MB_Data  = 32'hFFFF_FFFF;
      end
    end
  end

  // completion monitor + CS burst/gap length tracking
  always @(negedge clk) begin
    exp_t e;
    if (MB2IP_CS) begin
      if (gap_run > 0) begin gap_len = gap_run; gap_run = 0; end
      cs_run++;
    end else begin
      if (cs_run > 0) begin cs_len = cs_run; cs_run = 0; end
      gap_run++;
    end
    if (m0_ack || m1_ack) begin
      chk("ack_both", {63'd0, m0_ack & m1_ack}, 64'd0);
      chk("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_port", m1_ack ? 64'd1 : 64'd0, 64'(e.port));
        chk("ack_rdata", m1_ack ? 64'(m1_rdata) : 64'(m0_rdata), 64'(e.rdata));
        chk("ack_err", m1_ack ? 64'(m1_err) : 64'(m0_err), 64'(e.err));
        chk("loser_err", m1_ack ? 64'(m0_err) : 64'(m1_err), 64'd0);
      end
    end
  end

  task automatic xfer(input int port, input logic rnw, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    int   n;
    bit   to;
    int   lat;
    to  = (slv_lat == 0 || slv_lat > TO);
    lat = to ? TO : slv_lat;
    if (rnw && !to) model_rdata[port] = slv_rdata ^ addr;
    e.port  = port;
    e.rdata = model_rdata[port];
    e.err   = to ? 1'b1 : slv_err;
    sb.push_back(e);
    @(negedge clk);
    if (port == 0) begin
      m0_rnw = rnw; m0_addr = addr; m0_wdata = wdata; m0_be = be; m0_req = 1'b1;
    end else begin
      m1_rnw = rnw; m1_addr = addr; m1_wdata = wdata; m1_be = be; m1_req = 1'b1;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!MB2IP_CS && n < 10);
    chk("req_to_cs", 64'(n), 64'd1);
    chk("bus_rnw", 64'(MB2IP_RNW), 64'(rnw));
    chk("bus_addr", 64'(MB2IP_Addr), 64'(addr));
    chk("bus_wdata", 64'(MB2IP_Data), 64'(wdata));
    chk("bus_be", 64'(MB2IP_BE), 64'(be));
    n = 0;
    do begin @(negedge clk); n++; end while (!(port == 0 ? m0_ack : m1_ack) && n < 300);
    chk("cs_to_ack", 64'(n), 64'(lat + 1));
    if (port == 0) m0_req = 1'b0;
    else           m1_req = 1'b0;
  endtask

  task automatic contend(input int n_x);
    exp_t e;
    int   acks;
    int   n;
    for (int i = 0; i < n_x; i++) begin
      e.port = i % 2;
      model_rdata[e.port] = slv_rdata ^ ((e.port == 1) ? 32'h80 : 32'h40);
      e.rdata = model_rdata[e.port];
      e.err   = slv_err;
      sb.push_back(e);
    end
    @(negedge clk);
    m0_rnw = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h0; m0_be = 4'hF;
    m1_rnw = 1'b1; m1_addr = 32'h80; m1_wdata = 32'h0; m1_be = 4'hF;
    m0_req = 1'b1; m1_req = 1'b1;
    acks = 0;
    n = 0;
    while (acks < n_x && n < 400) begin
      @(negedge clk);
      n++;
      if (m0_ack || m1_ack) acks++;
    end
    chk("contend_acks", 64'(acks), 64'(n_x));
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    m0_req = 0; m0_rnw = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 0; m1_rnw = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    IP2MB_Data = '0; IP2MB_RdAck = 0; IP2MB_WrAck = 0; IP2MB_Error = 0;
    model_rdata[0] = '0;
    model_rdata[1] = '0;

    repeat (3) @(negedge clk);
    chk("rst_cs_rnw_be", {58'd0, MB2IP_CS, MB2IP_RNW, MB2IP_BE}, {58'd0, 1'b0, 1'b1, 4'h0});
    chk("rst_addr_data", {MB2IP_Addr, MB2IP_Data}, 64'd0);
    chk("rst_acks_errs", {60'd0, m0_ack, m0_err, m1_ack, m1_err}, 64'd0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
    chk("rst_busy_tocnt", {55'd0, busy, timeout_cnt}, 64'd0);
    rst_n = 1'b1;

    // spurious slave strobes while idle
    @(posedge clk); spur = 1'b1;
    @(posedge clk); spur = 1'b0;
    repeat (2) @(negedge clk);
    chk("spur_busy_cs", {62'd0, busy, MB2IP_CS}, 64'd0);
    chk("spur_acks", {60'd0, m0_ack, m0_err, m1_ack, m1_err}, 64'd0);
    chk("spur_rdata_tocnt", {24'd0, m0_rdata, timeout_cnt}, 64'd0);

    // contention straight out of reset: M0, M1, M0, M1
    slv_lat = 1;
    slv_rdata = 32'hA5A5_0000;
    contend(4);
    repeat (3) @(negedge clk);
    chk("contend_gap", 64'(gap_len), 64'd3);
    chk("contend_sb_empty", 64'(sb.size()), 64'd0);

    // single read, ack 2 cycles after CS
    slv_lat = 3;
    slv_rdata = 32'hDEAD_BEFF;
    xfer(0, 1'b1, 32'h0000_0010, 32'h0, 4'hF);
    chk("read_cs_len", 64'(cs_len), 64'd3);
    chk("read_rdata", 64'(m0_rdata), 64'hDEAD_BEEF);

    // write with slave error
    slv_lat = 2;
    slv_err = 1'b1;
    xfer(1, 1'b0, 32'h24, 32'h1234_5678, 4'b0011);
    slv_err = 1'b0;

    // silent slave: timeout
    slv_lat = 0;
    xfer(0, 1'b1, 32'h60, 32'h0, 4'hF);
    chk("to_cnt_1", 64'(timeout_cnt), 64'd1);
    chk("to_cs_len", 64'(cs_len), 64'(TO));

    // ack on the expiry cycle wins
    slv_lat = TO;
    xfer(0, 1'b1, 32'h64, 32'h0, 4'hF);
    chk("expiry_cnt_kept", 64'(timeout_cnt), 64'd1);
    chk("expiry_cs_len", 64'(cs_len), 64'(TO));

    // reset mid-transfer
    slv_lat = 0;
    @(negedge clk);
    m0_rnw = 1'b1; m0_addr = 32'h30; m0_wdata = 32'h0; m0_be = 4'hF; m0_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!MB2IP_CS && n < 10);
    chk("mid_cs_up", 64'(MB2IP_CS), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_busy", {62'd0, MB2IP_CS, busy}, 64'd0);
    chk("mid_rst_acks", {62'd0, m0_ack, m1_ack}, 64'd0);
    chk("mid_rst_tocnt", 64'(timeout_cnt), 64'd0);
    m0_req = 1'b0;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_no_ack", {62'd0, m0_ack, m1_ack}, 64'd0);

    slv_lat = 1;
    xfer(1, 1'b1, 32'h50, 32'h0, 4'hF);
    contend(2);

    // timeout counter saturation
    slv_lat = 0;
    for (int i = 0; i < 260; i++) xfer(0, 1'b0, 32'h70, 32'h1, 4'h1);
    chk("to_cnt_sat", 64'(timeout_cnt), 64'd255);

    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "global timeout");
  end

endmodule
